// File: rtl/spi_dma_rd_arb_if.sv
// Bundle of the per-channel request/response lines and the Avalon-MM read master port.
// The arbiter takes the slave modport; the traffic source and the bus model take the master modport.
interface spi_dma_rd_arb_if #(
  parameter int NC = 4,
  parameter int AW = 32,
  parameter int BL = 4,
  parameter int TW = 3
);
  logic [NC-1:0]          ch_req;
  logic [NC*AW-1:0]       ch_adr;
  logic [NC*(BL+1)-1:0]   ch_len;
  logic [NC-1:0]          ch_ack;
  logic [NC-1:0]          ch_rsp_val;
  logic [AW-1:0]          avm_address;
  logic [BL:0]            avm_burstcount;
  logic                   avm_read;
  logic                   avm_waitrequest;
  logic                   avm_readdatavalid;
  logic [TW:0]            out_cnt;
  logic                   err;

  modport slave (
    input  ch_req, ch_adr, ch_len, avm_waitrequest, avm_readdatavalid,
    output ch_ack, ch_rsp_val, avm_address, avm_burstcount, avm_read, out_cnt, err
  );

  modport master (
    output ch_req, ch_adr, ch_len, avm_waitrequest, avm_readdatavalid,
    input  ch_ack, ch_rsp_val, avm_address, avm_burstcount, avm_read, out_cnt, err
  );
endinterface

// File: rtl/spi_dma_rd_arb.sv
// Round-robin arbiter of NC DMA read channels onto one Avalon-MM burst master; a tag FIFO routes
// readdatavalid to the owner. One grant cycle then CMD until waitrequest drops; full FIFO stalls grants.
module spi_dma_rd_arb #(
  parameter int NC = 4,
  parameter int CW = 2,
  parameter int AW = 32,
  parameter int BL = 4,
  parameter int TW = 3
) (
  input logic             clk,
  input logic             rst_n,
  spi_dma_rd_arb_if.slave bus
);
  localparam logic [TW:0] FULL = (TW+1)'(1 << TW);

  typedef enum logic {IDLE, CMD} state_e;
  state_e r_state, w_state_nxt;

  logic [CW-1:0] r_last_grant;
  logic [CW-1:0] r_gnt_id;
  logic [AW-1:0] r_adr;
  logic [BL:0]   r_len;

  logic [CW-1:0] r_tag_id  [1 << TW];
  logic [BL:0]   r_tag_len [1 << TW];
  logic [TW-1:0] r_wr_ptr;
  logic [TW-1:0] r_rd_ptr;
  logic [TW:0]   r_cnt;
  logic [BL:0]   r_beat;

  logic          w_gnt_vld;
  logic [CW-1:0] w_gnt_id;
  logic          w_empty;
  logic          w_full;
  logic          w_grant;
  logic          w_push;
  logic          w_beat;
  logic          w_pop;
  logic [TW-1:0] w_rd_nxt;

  // First requester found scanning upward from the channel after the last winner.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int k = 1; k <= NC; k++) begin
      if (!w_gnt_vld && bus.ch_req[(int'(r_last_grant) + k) % NC]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = CW'((int'(r_last_grant) + k) % NC);
      end
    end
  end

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == FULL);
  assign w_grant  = (r_state == IDLE) && w_gnt_vld && !w_full;
  assign w_push   = (r_state == CMD) && !bus.avm_waitrequest;
  assign w_beat   = bus.avm_readdatavalid && !w_empty;
  assign w_pop    = w_beat && (r_beat <= (BL+1)'(1));
  assign w_rd_nxt = r_rd_ptr + TW'(1);

  always_comb begin
    w_state_nxt  = r_state;
    bus.avm_read = 1'b0;
    bus.ch_ack   = '0;
    case (r_state)
      IDLE: if (w_grant) w_state_nxt = CMD;
      CMD: begin
        bus.avm_read = 1'b1;
        if (!bus.avm_waitrequest) begin
          bus.ch_ack[r_gnt_id] = 1'b1;
          w_state_nxt          = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ch_rsp_val = '0;
    if (w_beat) bus.ch_rsp_val[r_tag_id[r_rd_ptr]] = 1'b1;
  end

  // Empty during reset already blocks ch_rsp_val; err needs the explicit gate.
  assign bus.err            = rst_n && bus.avm_readdatavalid && w_empty;
  assign bus.avm_address    = r_adr;
  assign bus.avm_burstcount = r_len;
  assign bus.out_cnt        = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= CW'(NC - 1);
      r_gnt_id     <= '0;
      r_adr        <= '0;
      r_len        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt_id     <= w_gnt_id;
        r_last_grant <= w_gnt_id;
        r_adr        <= bus.ch_adr[int'(w_gnt_id)*AW +: AW];
        r_len        <= bus.ch_len[int'(w_gnt_id)*(BL+1) +: BL+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_id[r_wr_ptr]  <= r_gnt_id;
      r_tag_len[r_wr_ptr] <= r_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_beat   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + TW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (TW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (TW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      // The next head is either an older queued tag or the one being pushed right now.
      if (w_pop) begin
        if (r_cnt > (TW+1)'(1)) r_beat <= r_tag_len[w_rd_nxt];
        else if (w_push)        r_beat <= r_len;
        else                    r_beat <= '0;
      end else if (w_beat) begin
        r_beat <= r_beat - (BL+1)'(1);
      end else if (w_push && w_empty) begin
        r_beat <= r_len;
      end
    end
  end
endmodule

// File: doc/spi_dma_rd_arb.md
SPI_DMA_RD_ARB -- requirements
Module: spi_dma_rd_arb

Interface
REQ-001 SHALL have parameter NC, default 4: number of DMA read channels, 2..8.
REQ-002 SHALL have parameter CW, default 2: channel-ID width, with 2**CW >= NC.
REQ-003 SHALL have parameter AW, default 32: address width.
REQ-004 SHALL have parameter BL, default 4: burst-length exponent; ch_len and avm_burstcount are BL+1 bits wide.
REQ-005 SHALL have parameter TW, default 3: tag FIFO depth is 2**TW outstanding bursts.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port ch_req, input, NC bits: per-channel burst request, held until acknowledged.
REQ-009 SHALL have port ch_adr, input, NC*AW bits: per-channel burst byte address; channel i occupies [i*AW +: AW].
REQ-010 SHALL have port ch_len, input, NC*(BL+1) bits: per-channel burst length in words, legal range 1..2**BL.
REQ-011 SHALL have port ch_ack, output, NC bits: one-cycle pulse when channel i's command is accepted by the bus.
REQ-012 SHALL have port ch_rsp_val, output, NC bits: readdatavalid routed to the owning channel.
REQ-013 SHALL have port avm_address, output, AW bits: Avalon-MM read address.
REQ-014 SHALL have port avm_burstcount, output, BL+1 bits: Avalon-MM burst count.
REQ-015 SHALL have port avm_read, output, 1 bit: Avalon-MM read strobe.
REQ-016 SHALL have port avm_waitrequest, input, 1 bit: Avalon-MM wait request.
REQ-017 SHALL have port avm_readdatavalid, input, 1 bit: Avalon-MM read data valid; readdata bypasses this block to every channel FIFO.
REQ-018 SHALL have port out_cnt, output, TW+1 bits: number of bursts issued and not fully returned.
REQ-019 SHALL have port err, output, 1 bit: one-cycle pulse on a readdatavalid received with no outstanding burst.

Function
REQ-020 SHALL implement a two-state FSM with states IDLE and CMD.
REQ-021 IDLE: avm_read=0; when ch_req!=0 and out_cnt<2**TW, SHALL grant one channel and go to CMD on the next edge.
REQ-022 Grant SHALL be round-robin: search starts at (last_grant+1) mod NC; last_grant resets to NC-1, so channel 0 wins first.
REQ-023 At grant SHALL register the channel ID, ch_adr[i] and ch_len[i]; avm_address and avm_burstcount are driven from these registers, stable for the whole CMD state.
REQ-024 CMD: avm_read=1; SHALL stay in CMD while avm_waitrequest=1.
REQ-025 CMD with avm_waitrequest=0 SHALL, in that same cycle, pulse ch_ack[granted]=1, push {ID,len} into the tag FIFO on the edge, and return to IDLE.
REQ-026 Commands SHALL be issued at most one per two cycles; no grant SHALL occur in CMD.
REQ-027 ch_req of a channel not granted SHALL have no effect on outputs; dropping ch_req in CMD SHALL NOT abort the command.
REQ-028 Response head: a beat counter loads the length of the FIFO head; on every avm_readdatavalid=1 SHALL assert ch_rsp_val[head ID] combinationally and decrement the counter.
REQ-029 On the last beat of the head burst SHALL pop the FIFO and load the next head's length.
REQ-030 ch_rsp_val SHALL be one-hot or zero.
REQ-031 Push and pop in the same cycle SHALL leave out_cnt unchanged.
REQ-032 A push into an empty FIFO SHALL make that entry the head on the next cycle.
REQ-033 out_cnt SHALL range 0..2**TW; FIFO pointers SHALL wrap modulo 2**TW.
REQ-034 Full FIFO SHALL block grants only; a command already in CMD SHALL be completed, since a grant implies a free slot.
REQ-035 avm_readdatavalid=1 with out_cnt=0 SHALL pulse err, assert no ch_rsp_val, and leave state unchanged.
REQ-036 ch_len outside 1..2**BL is outside contract and SHALL NOT be checked.

Reset
REQ-037 rst_n=0 SHALL asynchronously force: FSM=IDLE, avm_read=0, ch_ack=0, ch_rsp_val=0, err=0, out_cnt=0, FIFO empty, beat counter 0, last_grant=NC-1.
REQ-038 Reset asserted mid-burst SHALL discard all outstanding tags; the bus is reset on the same rst_n.
REQ-039 avm_address and avm_burstcount SHALL be 0 after reset.

Verification
REQ-040 Single channel: ch_req[1]=1, adr=0x1000, len=16, waitrequest=0 -> avm_read high 1 cycle with address 0x1000, burstcount 16, ch_ack[1] pulses, then 16 valids give ch_rsp_val[1]=1 x16 and out_cnt goes 1->0.
REQ-041 All four channels requesting continuously -> grant order 0,1,2,3,0,...; ch_ack pulses spaced 2 cycles apart.
REQ-042 waitrequest held 5 cycles in CMD -> address and burstcount stable, ch_ack asserted only in the release cycle.
REQ-043 TW=3, no readdatavalid -> exactly 8 commands issued, then avm_read stays 0; one full burst returned -> the 9th command issues.
REQ-044 Interleaved bursts ch2 len 4 then ch0 len 16 -> first 4 valids go to ch2, next 16 to ch0; push and pop in the same cycle keep out_cnt.
REQ-045 readdatavalid with out_cnt=0 -> err pulses 1 cycle; rst_n pulled low mid-burst -> avm_read=0 immediately and out_cnt=0.
